// File: rtl/mure_pkg.sv
// Shared widths and the per-instruction entry type for the trace block expander.
package mure_pkg;

    localparam int XLEN        = 32;
    localparam int IRETIRE_LEN = 8;
    localparam int ITYPE_LEN   = 4;
    localparam int CAUSE_LEN   = 5;
    localparam int PRIV_LEN    = 2;

    typedef struct packed {
        logic                 valid;
        logic                 compressed;
        logic [ITYPE_LEN-1:0] itype;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
        logic [XLEN-1:0]      pc;
    } fifo_entry_s;

endpackage

// File: rtl/block_expander_if.sv
// Descriptor, size-lookup and entry-output signals of block_expander, grouped by direction.
interface block_expander_if;

    logic                                block_valid_i;
    logic                                block_ready_o;
    logic [mure_pkg::IRETIRE_LEN-1:0]    iretire_i;
    logic                                ilastsize_i;
    logic [mure_pkg::ITYPE_LEN-1:0]      itype_i;
    logic [mure_pkg::CAUSE_LEN-1:0]      cause_i;
    logic [mure_pkg::XLEN-1:0]           tval_i;
    logic [mure_pkg::PRIV_LEN-1:0]       priv_i;
    logic [mure_pkg::XLEN-1:0]           iaddr_i;
    logic [mure_pkg::XLEN-1:0]           lookup_addr_o;
    logic                                lookup_compressed_i;
    mure_pkg::fifo_entry_s               fifo_entry_o;
    logic                                entry_ready_i;
    logic                                busy_o;
    logic                                error_o;

    modport slave (
        input  block_valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i,
        input  iaddr_i, lookup_compressed_i, entry_ready_i,
        output block_ready_o, lookup_addr_o, fifo_entry_o, busy_o, error_o
    );

    modport master (
        output block_valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i,
        output iaddr_i, lookup_compressed_i, entry_ready_i,
        input  block_ready_o, lookup_addr_o, fifo_entry_o, busy_o, error_o
    );

endinterface

// File: rtl/block_expander.sv
// Expands a retired-block descriptor into one fifo entry per instruction, sizing each PC via lookup.
// Malformed-block checking is compiled in with `define BLOCK_EXPANDER_CHECK_EN.
module block_expander
    import mure_pkg::*;
#(
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    block_expander_if.slave  bus_if
);

    typedef enum logic {IDLE, EXPAND} state_e;

    state_e                 state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [IRETIRE_LEN-1:0] rem_q, rem_d;
    logic [ITYPE_LEN-1:0]   itype_q;
    logic [CAUSE_LEN-1:0]   cause_q;
    logic [XLEN-1:0]        tval_q;
    logic [PRIV_LEN-1:0]    priv_q;

    logic                   latch_en;
    logic [IRETIRE_LEN-1:0] size;
    logic                   underflow;
    logic                   is_last;
    logic                   block_ready;
    logic [XLEN-1:0]        lookup_addr;
    fifo_entry_s            entry;
`ifdef BLOCK_EXPANDER_CHECK_EN
    logic                   ilastsize_q;
    logic                   err_evt;
    logic                   error_q;
`endif

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        rem_d       = rem_q;
        latch_en    = 1'b0;
        entry       = '0;
        lookup_addr = '0;
        block_ready = 1'b0;
`ifdef BLOCK_EXPANDER_CHECK_EN
        err_evt     = 1'b0;
`endif
        size      = bus_if.lookup_compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
        underflow = (rem_q == IRETIRE_LEN'(1)) && !bus_if.lookup_compressed_i;
`ifdef BLOCK_EXPANDER_CHECK_EN
        is_last   = (rem_q == size);
`else
        // An underflowing 32-bit tail is treated as the block's final instruction.
        is_last   = (rem_q == size) || underflow;
`endif

        unique case (state_q)
            IDLE: begin
                block_ready = 1'b1;
                if (bus_if.block_valid_i && (bus_if.iretire_i != '0)) begin
                    latch_en = 1'b1;
                    pc_d     = bus_if.iaddr_i;
                    rem_d    = bus_if.iretire_i;
                    state_d  = EXPAND;
                end
`ifdef BLOCK_EXPANDER_CHECK_EN
                if (bus_if.block_valid_i && (bus_if.iretire_i == '0)) begin
                    err_evt = 1'b1;
                end
`endif
            end
            EXPAND: begin
                lookup_addr = pc_q;
`ifdef BLOCK_EXPANDER_CHECK_EN
                if (underflow) begin
                    err_evt = 1'b1;
                    state_d = IDLE;
                end else
`endif
                begin
                    entry.valid      = 1'b1;
                    entry.pc         = pc_q;
                    entry.compressed = bus_if.lookup_compressed_i;
                    if (is_last) begin
                        entry.itype = itype_q;
                        entry.cause = cause_q;
                        entry.tval  = tval_q;
                        entry.priv  = priv_q;
                    end
                    if (bus_if.entry_ready_i) begin
                        pc_d  = pc_q + (XLEN'(size) << 1);
                        rem_d = rem_q - size;
                        if (is_last) begin
                            state_d = IDLE;
                        end
`ifdef BLOCK_EXPANDER_CHECK_EN
                        // Final size must agree with the descriptor's last-instruction size.
                        if (is_last && (ilastsize_q == bus_if.lookup_compressed_i)) begin
                            err_evt = 1'b1;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= '0;
            rem_q   <= '0;
            itype_q <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            priv_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rem_q   <= rem_d;
            if (latch_en) begin
                itype_q <= bus_if.itype_i;
                cause_q <= bus_if.cause_i;
                tval_q  <= bus_if.tval_i;
                priv_q  <= bus_if.priv_i;
            end
        end
    end

`ifdef BLOCK_EXPANDER_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ilastsize_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            if (latch_en) begin
                ilastsize_q <= bus_if.ilastsize_i;
            end
            error_q <= ERR_STICKY ? (error_q | err_evt) : err_evt;
        end
    end

    assign bus_if.error_o = error_q;
`else
    assign bus_if.error_o = 1'b0;
`endif

    assign bus_if.block_ready_o = block_ready;
    assign bus_if.lookup_addr_o = lookup_addr;
    assign bus_if.fifo_entry_o  = entry;
    assign bus_if.busy_o        = (state_q == EXPAND);

endmodule

// File: tb/tb_block_expander.sv
// Self-checking bench for block_expander: directed blocks plus random blocks scored against a queue model.
module tb_block_expander;
    import mure_pkg::*;

`ifdef BLOCK_EXPANDER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] cmap = '0;
    int          checks = 0;
    int          failures = 0;

    fifo_entry_s exp_q[$];
    fifo_entry_s got_q[$];
    bit          exp_err_acc = 1'b0;
    bit          exp_uf = 1'b0;

    block_expander_if bus_if();

    block_expander #(.ERR_STICKY(1'b1)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Instruction-size memory: one bit per halfword slot, 1 = compressed.
    assign bus_if.lookup_compressed_i = cmap[bus_if.lookup_addr_o[6:1]];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks the block halfword by halfword and lists the entries it must produce.
    function automatic void model(input logic [31:0] iaddr, input int iretire, input bit ils,
                                  input logic [3:0] itype, input logic [4:0] cause,
                                  input logic [31:0] tval, input logic [1:0] priv);
        logic [31:0] pc;
        int          rem;
        int          sz;
        bit          c;
        bit          last;
        fifo_entry_s e;
        pc  = iaddr;
        rem = iretire;
        exp_q.delete();
        exp_uf = 1'b0;
        if (rem == 0) begin
            if (CHK) exp_err_acc = 1'b1;
            return;
        end
        while (rem > 0) begin
            c  = cmap[pc[6:1]];
            sz = c ? 1 : 2;
            if (CHK && rem == 1 && sz == 2) begin
                exp_err_acc = 1'b1;
                exp_uf      = 1'b1;
                return;
            end
            last = (rem <= sz);
            e = '0;
            e.valid      = 1'b1;
            e.pc         = pc;
            e.compressed = c;
            if (last) begin
                e.itype = itype;
                e.cause = cause;
                e.tval  = tval;
                e.priv  = priv;
            end
            exp_q.push_back(e);
            if (last) begin
                if (CHK && (ils == c)) exp_err_acc = 1'b1;
                return;
            end
            pc  = pc + 32'(2 * sz);
            rem = rem - sz;
        end
    endfunction

    task automatic send_block(input logic [31:0] iaddr, input int iretire, input bit ils,
                              input logic [3:0] itype, input logic [4:0] cause,
                              input logic [31:0] tval, input logic [1:0] priv,
                              input bit rand_ready, input int stall_idx, input string tag);
        int          busy_cycles = 0;
        int          stall_left = 3;
        int          stall_seen = 0;
        bit          done = 1'b0;
        fifo_entry_s stall_e = '0;
        model(iaddr, iretire, ils, itype, cause, tval, priv);
        got_q.delete();
        @(negedge clk);
        check({tag, "_accept_ready"}, bus_if.block_ready_o, 1);
        bus_if.block_valid_i = 1'b1;
        bus_if.iaddr_i       = iaddr;
        bus_if.iretire_i     = IRETIRE_LEN'(iretire);
        bus_if.ilastsize_i   = ils;
        bus_if.itype_i       = itype;
        bus_if.cause_i       = cause;
        bus_if.tval_i        = tval;
        bus_if.priv_i        = priv;
        @(negedge clk);
        bus_if.block_valid_i = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (!bus_if.busy_o) begin
                done = 1'b1;
                break;
            end
            busy_cycles++;
            if (got_q.size() == stall_idx && stall_left > 0 && bus_if.fifo_entry_o.valid) begin
                bus_if.entry_ready_i = 1'b0;
                stall_left--;
            end else begin
                bus_if.entry_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (got_q.size() == stall_idx && bus_if.fifo_entry_o.valid) begin
                if (stall_seen == 0) stall_e = bus_if.fifo_entry_o;
                else check({tag, "_stall_stable"}, bus_if.fifo_entry_o, stall_e);
                stall_seen++;
            end
            if (bus_if.fifo_entry_o.valid && bus_if.entry_ready_i) begin
                got_q.push_back(bus_if.fifo_entry_o);
            end
        end
        bus_if.entry_ready_i = 1'b1;
        check({tag, "_done"}, done, 1);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_entry%0d", tag, i), got_q[i], exp_q[i]);
        end
        if (!rand_ready && stall_idx < 0) begin
            check({tag, "_busy_cycles"}, busy_cycles, exp_q.size() + int'(exp_uf));
        end
        if (stall_idx >= 0) begin
            check({tag, "_stall_cycles"}, stall_seen, 4);
        end
        check({tag, "_error"}, bus_if.error_o, exp_err_acc);
        check({tag, "_idle_outputs"}, {bus_if.lookup_addr_o, bus_if.fifo_entry_o}, 0);
        check({tag, "_ready_after"}, bus_if.block_ready_o, 1);
    endtask

    initial begin
        bit any_valid;
        bus_if.block_valid_i = 1'b0;
        bus_if.iaddr_i       = '0;
        bus_if.iretire_i     = '0;
        bus_if.ilastsize_i   = 1'b0;
        bus_if.itype_i       = '0;
        bus_if.cause_i       = '0;
        bus_if.tval_i        = '0;
        bus_if.priv_i        = '0;
        bus_if.entry_ready_i = 1'b1;

        #1;
        check("reset_entry", bus_if.fifo_entry_o, 0);
        check("reset_busy", bus_if.busy_o, 0);
        check("reset_error", bus_if.error_o, 0);
        check("reset_lookup", bus_if.lookup_addr_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_ready", bus_if.block_ready_o, 1);

        // Two 32-bit instructions then a 16-bit one.
        cmap = 64'h10;
        send_block(32'h1000, 5, 1'b0, 4'd0, 5'd0, 32'h0, 2'd0, 1'b0, -1, "basic");

        // Single compressed instruction carrying the closing attributes.
        cmap = 64'h1;
        send_block(32'h2000, 1, 1'b0, 4'd1, 5'd2, 32'hDEAD, 2'd3, 1'b0, -1, "single");

        // Second entry held for three extra cycles.
        cmap = 64'h10;
        send_block(32'h1000, 5, 1'b0, 4'd0, 5'd0, 32'h0, 2'd0, 1'b0, 1, "stall");

        // Odd halfword count over 32-bit instructions: underflow on the tail.
        cmap = 64'h0;
        send_block(32'h3000, 3, 1'b1, 4'd5, 5'd7, 32'h1234, 2'd1, 1'b0, -1, "underflow");

        // Zero-length descriptor, then a last-size mismatch.
        send_block(32'h3800, 0, 1'b0, 4'd2, 5'd1, 32'h55, 2'd0, 1'b0, -1, "zero_len");
        cmap = 64'h1;
        send_block(32'h4000, 1, 1'b1, 4'd3, 5'd4, 32'hBEEF, 2'd2, 1'b0, -1, "size_mismatch");

        // Reset in the middle of a four-instruction block.
        cmap = 64'h0;
        @(negedge clk);
        bus_if.block_valid_i = 1'b1;
        bus_if.iaddr_i       = 32'h5000;
        bus_if.iretire_i     = IRETIRE_LEN'(8);
        bus_if.ilastsize_i   = 1'b1;
        @(negedge clk);
        bus_if.block_valid_i = 1'b0;
        @(negedge clk);
        check("rst_second_entry_pc", bus_if.fifo_entry_o.pc, 32'h5004);
        rst_n = 1'b0;
        #1;
        check("rst_entry_zero", bus_if.fifo_entry_o, 0);
        check("rst_busy_zero", bus_if.busy_o, 0);
        check("rst_lookup_zero", bus_if.lookup_addr_o, 0);
        check("rst_error_zero", bus_if.error_o, 0);
        exp_err_acc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", bus_if.block_ready_o, 1);
        any_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            any_valid = any_valid | bus_if.fifo_entry_o.valid | bus_if.busy_o;
        end
        check("rst_no_entries", any_valid, 0);

        // Random blocks with random size maps and random downstream stalls.
        for (int n = 0; n < 40; n++) begin
            int rl;
            cmap = {$urandom, $urandom};
            rl   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            send_block($urandom & 32'hFFFF_FFFE, rl, 1'($urandom), 4'($urandom), 5'($urandom),
                       $urandom, 2'($urandom), 1'b1, -1, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
